fcmp_pipe: RTL and testbench

//  Parametrised, pipelined floating-point comparator for the FPU: FEQ, FLT, FLE in one

---
 rtl/fcmp_pipe.sv | 130 +++++++++++++
 tb/tb_fcmp_pipe.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcmp_pipe.sv
// Two-stage pipelined floating-point compare (FEQ/FLT/FLE) with valid/ready on both sides.
// Stage 1 decodes operands into sign/magnitude relations; stage 2 forms the 1-bit result.
module fcmp_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_op,
  input  logic [EXP_W+MAN_W:0]       in_x,
  input  logic [EXP_W+MAN_W:0]       in_y,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_z,
  output logic                       out_nan,
  output logic [TAG_W-1:0]           out_tag
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int M_W = EXP_W + MAN_W;

  localparam logic [1:0] OP_FEQ = 2'b00;
  localparam logic [1:0] OP_FLT = 2'b01;
  localparam logic [1:0] OP_FLE = 2'b10;

  // Operand decode
  logic [EXP_W-1:0] x_exp, y_exp;
  logic [MAN_W-1:0] x_man, y_man;
  logic             x_zero, y_zero, x_nan, y_nan;
  logic [M_W-1:0]   x_mag, y_mag;

  assign x_exp  = in_x[W-2 -: EXP_W];
  assign y_exp  = in_y[W-2 -: EXP_W];
  assign x_man  = in_x[MAN_W-1:0];
  assign y_man  = in_y[MAN_W-1:0];
  // Denormals flush to zero, so a zero exponent alone marks the operand as zero.
  assign x_zero = (x_exp == '0);
  assign y_zero = (y_exp == '0);
  assign x_nan  = (&x_exp) & (|x_man);
  assign y_nan  = (&y_exp) & (|y_man);
  assign x_mag  = x_zero ? '0 : in_x[M_W-1:0];
  assign y_mag  = y_zero ? '0 : in_y[M_W-1:0];

  // Handshake
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_adv, s2_adv;

  assign s2_adv     = ~s2_valid_q | out_ready;
  assign s1_adv     = ~s1_valid_q | s2_adv;
  assign in_ready   = s1_adv;
  assign s1_valid_d = s1_adv ? in_valid : s1_valid_q;
  assign s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;

  // Stage 1 registers
  logic [1:0]       s1_op_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             s1_xs_q, s1_ys_q, s1_lt_q, s1_eq_q, s1_nan_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_tag_q   <= '0;
      s1_xs_q    <= 1'b0;
      s1_ys_q    <= 1'b0;
      s1_lt_q    <= 1'b0;
      s1_eq_q    <= 1'b0;
      s1_nan_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_adv && in_valid) begin
        s1_op_q  <= in_op;
        s1_tag_q <= in_tag;
        s1_xs_q  <= in_x[W-1] & ~x_zero;
        s1_ys_q  <= in_y[W-1] & ~y_zero;
        s1_lt_q  <= (x_mag < y_mag);
        s1_eq_q  <= (x_mag == y_mag);
        s1_nan_q <= x_nan | y_nan;
      end
    end
  end

  // Stage 2 result
  logic eq, lt, z_d;

  always_comb begin
    eq  = s1_eq_q & (s1_xs_q == s1_ys_q);
    lt  = (s1_xs_q & ~s1_ys_q)
        | (~s1_xs_q & ~s1_ys_q & s1_lt_q)
        | (s1_xs_q & s1_ys_q & ~s1_lt_q & ~s1_eq_q);
    z_d = 1'b0;
    case (s1_op_q)
      OP_FEQ:  z_d = eq;
      OP_FLT:  z_d = lt;
      OP_FLE:  z_d = lt | eq;
      default: z_d = 1'b0;
    endcase
    if (s1_nan_q) z_d = 1'b0;
  end

  logic             z_q, nan_q;
  logic [TAG_W-1:0] tag_q;

  // Data only loads alongside a real op, so a held result never changes under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      z_q        <= 1'b0;
      nan_q      <= 1'b0;
      tag_q      <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_adv && s1_valid_q) begin
        z_q   <= z_d;
        nan_q <= s1_nan_q;
        tag_q <= s1_tag_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_z     = z_q;
  assign out_nan   = nan_q;
  assign out_tag   = tag_q;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Bench for fcmp_pipe: directed IEEE corner cases plus randomized traffic with random
// back-pressure, scored against an ordered-key model of float comparison.
module tb_fcmp_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int TAG_W = 5;
  localparam int W     = 1 + EXP_W + MAN_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [1:0]       in_op;
  logic [W-1:0]     in_x, in_y;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready, out_z, out_nan;
  logic [TAG_W-1:0] out_tag;

  fcmp_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_nan(out_nan), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             z;
    logic             nan;
    logic [TAG_W-1:0] tag;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  bit   held = 0;
  res_t held_r;
  int   rdy_low = 0;

  function automatic bit is_nan(logic [W-1:0] v);
    return (v[W-2 -: EXP_W] == '1) && (v[MAN_W-1:0] != '0);
  endfunction

  // Map a float onto a signed integer whose ordering is the float ordering.
  function automatic longint fkey(logic [W-1:0] v);
    longint m;
    m = (v[W-2 -: EXP_W] == '0) ? 64'sd0 : longint'({1'b0, v[W-2:0]});
    return v[W-1] ? -m : m;
  endfunction

  function automatic res_t model(logic [1:0] op, logic [W-1:0] x, logic [W-1:0] y,
                                 logic [TAG_W-1:0] tag);
    res_t   r;
    longint kx, ky;
    r.tag = tag;
    r.nan = is_nan(x) || is_nan(y);
    kx = fkey(x);
    ky = fkey(y);
    case (op)
      2'd0:    r.z = (kx == ky);
      2'd1:    r.z = (kx <  ky);
      2'd2:    r.z = (kx <= ky);
      default: r.z = 1'b0;
    endcase
    if (r.nan) r.z = 1'b0;
    return r;
  endfunction

  function automatic logic [W-1:0] rand_fp();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0:       return {s, 8'h00, 23'($urandom)};
      1:       return {s, 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
      2:       return {s, 8'hFF, 23'h0};
      3:       return {s, 8'($urandom_range(126, 128)), 2'($urandom_range(0, 3)), 21'h0};
      default: return $urandom;
    endcase
  endfunction

  // One clock of traffic: drive after negedge, account for handshakes that the next
  // posedge will complete, and score any result taken.
  task automatic cycle(input logic v, input logic [1:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [TAG_W-1:0] tag,
                       input logic ordy, input bit use_exp, input res_t ex,
                       output bit acc);
    res_t e;
    @(negedge clk);
    in_valid = v; in_op = op; in_x = x; in_y = y; in_tag = tag; out_ready = ordy;
    #1;
    if (held) begin
      checks++;
      if (out_valid !== 1'b1 || out_z !== held_r.z || out_nan !== held_r.nan ||
          out_tag !== held_r.tag) begin
        errors++;
        $display("FAIL stall_hold: got v=%b z=%b nan=%b tag=%0d, want v=1 z=%b nan=%b tag=%0d",
                 out_valid, out_z, out_nan, out_tag, held_r.z, held_r.nan, held_r.tag);
      end
    end
    acc = v && (in_ready === 1'b1);
    if (in_ready !== 1'b1) rdy_low++;
    if (acc) exp_q.push_back(use_exp ? ex : model(op, x, y, tag));
    if (out_valid === 1'b1 && ordy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_result: got z=%b tag=%0d, want no result", out_z, out_tag);
      end else begin
        e = exp_q.pop_front();
        if (out_z !== e.z || out_nan !== e.nan || out_tag !== e.tag) begin
          errors++;
          $display("FAIL result: got z=%b nan=%b tag=%0d, want z=%b nan=%b tag=%0d",
                   out_z, out_nan, out_tag, e.z, e.nan, e.tag);
        end
      end
    end
    held     = (out_valid === 1'b1) && !ordy;
    held_r.z = out_z; held_r.nan = out_nan; held_r.tag = out_tag;
  endtask

  task automatic drain();
    bit   acc;
    res_t nul;
    nul = '{z: 1'b0, nan: 1'b0, tag: '0};
    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      cycle(1'b0, 2'd0, '0, '0, '0, 1'b1, 1'b0, nul, acc);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_x = '0; in_y = '0; in_tag = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_z !== 1'b0 || out_nan !== 1'b0 || out_tag !== '0) begin
      errors++;
      $display("FAIL reset_out: got v=%b z=%b nan=%b tag=%0d, want all 0",
               out_valid, out_z, out_nan, out_tag);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd0; in_x = 32'h3F800000; in_y = 32'h3F800000;
    in_tag = 5'd3; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL lat_accept: in_ready=%b, want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL lat_early: out_valid=%b after 1 cycle, want 0", out_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_z !== 1'b1 || out_nan !== 1'b0 || out_tag !== 5'd3) begin
      errors++;
      $display("FAIL lat_result: got v=%b z=%b nan=%b tag=%0d, want v=1 z=1 nan=0 tag=3",
               out_valid, out_z, out_nan, out_tag);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL lat_single: out_valid=%b after take, want 0", out_valid);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  op[12] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd3,
                            2'd1, 2'd2};
    logic [31:0] xs[12] = '{32'h3F800000, 32'h80000000, 32'h80000000, 32'h80000000,
                            32'hBF800000, 32'hC0000000, 32'hBF800000, 32'h7FC00000,
                            32'h7F800000, 32'h3F800000, 32'h3F800000, 32'hFF800000};
    logic [31:0] ys[12] = '{32'h3F800000, 32'h00000001, 32'h00000001, 32'h00000001,
                            32'hC0000000, 32'hBF800000, 32'hBF800000, 32'h7FC00000,
                            32'h3F800000, 32'h40000000, 32'h7F800000, 32'h00000000};
    logic        zs[12] = '{1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1};
    logic        ns[12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    bit   acc;
    res_t e;
    for (int i = 0; i < 12; i++) begin
      e = '{z: zs[i], nan: ns[i], tag: TAG_W'(i + 3)};
      cycle(1'b1, op[i], xs[i], ys[i], TAG_W'(i + 3), 1'b1, 1'b1, e, acc);
      checks++;
      if (!acc) begin
        errors++; $display("FAIL directed_accept: vector %0d not accepted, want accepted", i);
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    bit              acc;
    int              idx;
    int              taken;
    res_t            nul;
    logic [W-1:0]    x, y;
    nul = '{z: 1'b0, nan: 1'b0, tag: '0};
    idx = 0; rdy_low = 0;
    taken = exp_q.size();
    x = rand_fp(); y = rand_fp();
    for (int c = 0; c < 10; c++) begin
      cycle(idx < 4, 2'(idx % 3), x, y, TAG_W'(20 + idx), !(c >= 2 && c < 5), 1'b0, nul, acc);
      if (acc) begin
        idx++; x = rand_fp(); y = rand_fp();
      end
    end
    checks++;
    if (idx != 4) begin
      errors++; $display("FAIL b2b_accepts: got %0d, want 4", idx);
    end
    checks++;
    if (rdy_low != 3) begin
      errors++; $display("FAIL b2b_in_ready_low: got %0d cycles, want 3", rdy_low);
    end
    drain();
  endtask

  task automatic test_random();
    bit           acc;
    res_t         nul;
    logic [W-1:0] x, y;
    nul = '{z: 1'b0, nan: 1'b0, tag: '0};
    for (int c = 0; c < 600; c++) begin
      x = rand_fp();
      case ($urandom_range(0, 7))
        0, 1:    y = x;
        2:       y = x ^ {1'b1, 31'h0};
        default: y = rand_fp();
      endcase
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), x, y,
            TAG_W'($urandom), 1'($urandom_range(0, 2) != 0), 1'b0, nul, acc);
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    bit   acc;
    res_t nul;
    nul = '{z: 1'b0, nan: 1'b0, tag: '0};
    for (int c = 0; c < 3; c++)
      cycle(1'b1, 2'd0, 32'h3F800000, 32'h3F800000, TAG_W'(c), 1'b0, 1'b0, nul, acc);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: got out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    held = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_flush: cycle %0d out_valid=%b in_ready=%b, want 0/1",
                 c, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
